// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave controller.
package spi_pkg;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

  localparam int         SPI_DATA_W_DEF     = 8;
  localparam logic [7:0] SPI_FILL_BYTE_DEF  = 8'h00;
  // The system clock must run at least this many times faster than sclk.
  localparam int         SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave with oversampled inputs, rx strobes and a one-entry tx holding buffer.
// Optional SPI_SLAVE_FRAME_ERR_EN adds o_frame_err (aborted byte or tx underrun).
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int                DATA_W    = SPI_DATA_W_DEF,
  parameter logic [DATA_W-1:0] FILL_BYTE = DATA_W'(SPI_FILL_BYTE_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  , output logic            o_frame_err
`endif
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state, state_nxt;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic              mosi_meta, mosi_s;
  logic [DATA_W-1:0] tx_shift, rx_shift, rx_next, buf_data, rx_data;
  logic [CNT_W-1:0]  bit_cnt;
  logic              buf_full, rx_valid;
  logic              in_frame, frame_start, sample, boundary, shift_out, load, tx_accept;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SPI_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SPI_IDLE:  if (cs_fall) state_nxt = SPI_SHIFT;
      SPI_SHIFT: if (cs_rise) state_nxt = SPI_IDLE;
      default:   state_nxt = SPI_IDLE;
    endcase
  end

  // A chip-select release takes priority over any sclk edge seen in the same cycle.
  assign in_frame    = (state == SPI_SHIFT) && !cs_rise;
  assign frame_start = (state == SPI_IDLE) && cs_fall;
  assign sample      = in_frame && sclk_rise;
  assign boundary    = in_frame && sclk_fall && (bit_cnt == '0);
  assign shift_out   = in_frame && sclk_fall && (bit_cnt != '0);
  assign load        = frame_start || boundary;
  assign tx_accept   = i_tx_valid && !buf_full;
  assign rx_next     = {rx_shift[DATA_W-2:0], mosi_s};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      mosi_meta <= i_mosi;
      mosi_s    <= mosi_meta;
      rx_valid  <= 1'b0;

      if (load)           tx_shift <= buf_full ? buf_data : FILL_BYTE;
      else if (shift_out) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      if (frame_start) begin
        bit_cnt <= '0;
      end else if (sample) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // A full buffer never accepts, so a write can only land in a load cycle when the
      // load itself took FILL_BYTE; the written byte then waits for the next boundary.
      if (load && buf_full) begin
        buf_full <= 1'b0;
      end else if (tx_accept) begin
        buf_full <= 1'b1;
        buf_data <= i_tx_data;
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err;

  // Frame entry is not an underrun: only in-frame byte-boundary reloads are flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) frame_err <= 1'b0;
    else       frame_err <= ((state == SPI_SHIFT) && cs_rise && (bit_cnt != '0))
                          || (boundary && !buf_full);
  end

  assign o_frame_err = frame_err;
`endif

  assign o_miso     = (state == SPI_SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
  assign o_busy     = (state == SPI_SHIFT);
  assign o_tx_ready = !buf_full;
  assign o_rx_data  = rx_data;
  assign o_rx_valid = rx_valid;

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) that answers the SPI master inside `top_controller`, enabling board-to-board and loopback tests of the master. It oversamples the external `i_sclk`, `i_cs_n` and `i_mosi` on the system clock. Received bytes are delivered as one-cycle strobes. Transmit bytes come from a one-entry holding buffer with a valid/ready handshake.

## Interface
- `DATA_W`, default 8: frame width in bits.
- `FILL_BYTE`, default `8'h00`: byte shifted out when the transmit buffer is empty at a frame boundary.
- `i_clk`, in, 1: system clock. Must be at least 8x the `i_sclk` frequency.
- `i_rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `i_sclk`, in, 1: SPI clock from the master (asynchronous).
- `i_cs_n`, in, 1: chip select, active low (asynchronous).
- `i_mosi`, in, 1: master-out data (asynchronous).
- `o_miso`, out, 1: slave-out data.
- `i_tx_data`, in, `DATA_W`: byte to transmit.
- `i_tx_valid`, in, 1: `i_tx_data` is valid.
- `o_tx_ready`, out, 1: holding buffer is empty. A write is accepted when `i_tx_valid` and `o_tx_ready` are both high.
- `o_rx_data`, out, `DATA_W`: last complete received byte.
- `o_rx_valid`, out, 1: one-cycle strobe; `o_rx_data` updated.
- `o_busy`, out, 1: chip select is active (synchronized).
- `o_frame_err`, out, 1: present only with `SPI_SLAVE_FRAME_ERR_EN`.

## Operation
- `i_sclk`, `i_cs_n` and `i_mosi` each pass through a 2-flop synchronizer. Rising and falling edge strobes are derived from the synchronized `sclk` and `cs_n`.
- State machine:
  - IDLE → SHIFT on the synchronized `cs_n` falling edge.
  - SHIFT → IDLE on the synchronized `cs_n` rising edge.
- Entering SHIFT:
  - `tx_shift` loads the holding buffer if it is full; the buffer empties and `o_tx_ready` rises.
  - Otherwise `tx_shift` loads `FILL_BYTE`.
  - `bit_cnt` is set to 0.
- SCLK rising edge in SHIFT:
  - `rx_shift` becomes `{rx_shift[DATA_W-2:0], mosi_s}`.
  - `bit_cnt` increments and wraps DATA_W-1 → 0.
  - On the wrap: `o_rx_data` takes the completed byte and `o_rx_valid` pulses for 1 cycle.
- SCLK falling edge in SHIFT:
  - If `bit_cnt == 0` (byte boundary): `tx_shift` reloads from the buffer or `FILL_BYTE`, using the same rule as frame entry.
  - Otherwise `tx_shift` shifts left by 1.
- `o_miso = tx_shift[DATA_W-1]` in SHIFT, 0 in IDLE.
- Back-to-back bytes inside one chip-select window are supported without gaps.
- Chip select rising mid-byte (`bit_cnt != 0`):
  - The partial byte is discarded; no `o_rx_valid`.
  - The loaded tx byte is dropped and not re-queued.
  - Return to IDLE.
- Buffer write in the same cycle as a boundary load: the write is only accepted when the buffer is empty. The boundary load therefore takes `FILL_BYTE`, and the written byte is kept for the next boundary.
- `i_rst` mid-frame: immediate return to IDLE. The buffer empties and the partial byte is lost.
- Reset values: `o_miso` = 0, `o_rx_data` = 0, `o_rx_valid` = 0, `o_tx_ready` = 1, `o_busy` = 0, `o_frame_err` = 0.

## Timing
- Input-to-internal latency: 2 cycles for synchronization, plus 1 cycle for the edge strobe.
- `o_busy` rises 3 cycles after `i_cs_n` falls.
- `o_miso` shows the MSB 3 cycles after `i_cs_n` falls. The master must hold at least half an SCLK period before its first rising edge; this is satisfied at 8x oversampling.
- `o_miso` changes 3 cycles after each SCLK falling edge, well inside the half-period the master has before sampling.
- `o_rx_valid` asserts 3 cycles after the DATA_W-th SCLK rising edge, for exactly 1 cycle.
- `o_tx_ready` rises the cycle after a buffer load consumes the byte. It falls the cycle after an accepted write.

## Configuration
- `SPI_SLAVE_FRAME_ERR_EN` defined:
  - `o_frame_err` port exists.
  - It pulses for 1 cycle when chip select deasserts with `bit_cnt != 0`.
  - It also pulses when a boundary load finds the buffer empty, i.e. a tx underrun.
- Not defined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package `spi_pkg`:
  - state enum (`SPI_IDLE`, `SPI_SHIFT`)
  - default `DATA_W` and `FILL_BYTE` constants
  - minimum oversample ratio constant (8)
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall strobe generation. Instantiated for `sclk` and `cs_n`; `mosi` uses the synchronizer only.

## Test plan
- Load 0xA5, then master sends 0x3C at sclk = clk/10 → `o_miso` bit sequence 1,0,1,0,0,1,0,1; `o_rx_data` = 0x3C with one `o_rx_valid` pulse; `o_tx_ready` returns to 1.
- No tx load, master sends 0xAA → MISO returns `FILL_BYTE` 0x00; `o_rx_data` = 0xAA; with the macro, `o_frame_err` pulses once for the underrun.
- Three bytes in one chip-select window (0x11, 0x22, 0x33), tx written after each `o_tx_ready` (0xC1, 0xC2, 0xC3) → three `o_rx_valid` pulses in order; MISO matches each tx byte.
- Chip select deasserted after 5 bits → no `o_rx_valid`; next frame receives correctly; with the macro, one `o_frame_err` pulse.
- `i_rst` asserted mid-byte → all outputs at reset values next cycle; next frame works normally.
- Write asserted on the exact cycle of a boundary load with the buffer empty → `FILL_BYTE` sent now; written byte sent on the following byte.
